// File: rtl/ravenoc_axi_pkt_master_pkg.sv
// Shared types for the RaveNoC AXI packet master: bus widths, AXI channel structs,
// write/read FSM state encodings and the beat-size constant.
package ravenoc_axi_pkt_master_pkg;

  localparam int AXI_ADDR_WIDTH   = 32;
  localparam int AXI_DATA_WIDTH   = 32;
  localparam int AXI_ALEN_WIDTH   = 8;
  localparam int AXI_TXN_ID_WIDTH = 1;
  localparam int AXI_USER_WIDTH   = 1;
  localparam int NumVirtChn       = 3;
  localparam int AxiBeatSize      = $clog2(AXI_DATA_WIDTH / 8);

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_INCR   = 2'b01;

  typedef logic [AXI_ADDR_WIDTH-1:0]   axi_addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0]   axi_data_t;
  typedef logic [AXI_ALEN_WIDTH-1:0]   axi_alen_t;
  typedef logic [AXI_TXN_ID_WIDTH-1:0] axi_id_t;
  typedef logic [AXI_USER_WIDTH-1:0]   axi_user_t;

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP}  pkt_wr_st_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_DRAIN} pkt_rd_st_t;

  typedef struct packed {
    axi_id_t                   awid;
    axi_addr_t                 awaddr;
    axi_alen_t                 awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    logic [3:0]                awregion;
    axi_user_t                 awuser;
    logic                      awvalid;
    axi_data_t                 wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                      wlast;
    axi_user_t                 wuser;
    logic                      wvalid;
    logic                      bready;
    axi_id_t                   arid;
    axi_addr_t                 araddr;
    axi_alen_t                 arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [3:0]                arqos;
    logic [3:0]                arregion;
    axi_user_t                 aruser;
    logic                      arvalid;
    logic                      rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    axi_id_t    bid;
    logic [1:0] bresp;
    axi_user_t  buser;
    logic       bvalid;
    logic       arready;
    axi_id_t    rid;
    axi_data_t  rdata;
    logic [1:0] rresp;
    logic       rlast;
    axi_user_t  ruser;
    logic       rvalid;
  } s_axi_miso_t;

  function automatic logic axi_resp_err(input logic [1:0] resp);
    return resp != AXI_OKAY;
  endfunction

endpackage

// File: rtl/ravenoc_axi_pkt_master_if.sv
// AXI4 master/slave bundle between the packet master and one NI slave slot.
interface ravenoc_axi_pkt_master_if;
  import ravenoc_axi_pkt_master_pkg::*;

  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  modport master (output axi_mosi, input axi_miso);
  modport slave  (input axi_mosi, output axi_miso);
endinterface

// File: rtl/ravenoc_rr_arb.sv
// Round-robin picker over N request bits; the pointer moves past the served index
// whenever advance is asserted with a pending request.
module ravenoc_rr_arb #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_axi,
  input  logic            arst_axi,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic            gnt_valid,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(idx);
      end
    end
  end

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      ptr_q <= '0;
    end else if (advance && gnt_valid) begin
      ptr_q <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ravenoc_axi_pkt_master.sv
// AXI4 initiator turning PE packet send/receive requests into NI write/read bursts.
// Optional RAVENOC_PKT_MASTER_AUTO_RD_EN: IRQ-driven round-robin auto reads.
module ravenoc_axi_pkt_master
  import ravenoc_axi_pkt_master_pkg::*;
#(
  parameter axi_id_t AXI_ID             = '0,
  parameter int      MAX_OUTSTANDING_RD = 1
) (
  input  logic                  clk_axi,
  input  logic                  arst_axi,
  input  logic                  tx_req_valid,
  output logic                  tx_req_ready,
  input  axi_addr_t             tx_addr,
  input  axi_alen_t             tx_len,
  input  logic                  txd_valid,
  output logic                  txd_ready,
  input  axi_data_t             txd_data,
  output logic                  tx_done,
  output logic                  tx_err,
  input  logic                  rx_req_valid,
  output logic                  rx_req_ready,
  input  axi_addr_t             rx_addr,
  input  axi_alen_t             rx_len,
  output logic                  rxd_valid,
  input  logic                  rxd_ready,
  output axi_data_t             rxd_data,
  output logic                  rxd_last,
  output logic                  rxd_err,
  input  logic [NumVirtChn-1:0] irq_vcs,
  ravenoc_axi_pkt_master_if.master axi
);

  pkt_wr_st_t  wr_st, wr_st_nxt;
  axi_addr_t   wr_addr_q;
  axi_alen_t   wr_len_q, wr_cnt_q;
  pkt_rd_st_t  rd_st, rd_st_nxt;
  axi_addr_t   rd_addr_q;
  axi_alen_t   rd_len_q, rd_cnt_q;
  logic        rd_err_q;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  logic w_hs, r_hs, rd_at_len, beat_err, rd_launch;
  logic unused_cfg;

  assign miso       = axi.axi_miso;
  assign axi.axi_mosi = mosi;
  assign unused_cfg = (MAX_OUTSTANDING_RD != 1) ^ (^{miso.bid, miso.buser, miso.rid, miso.ruser});

`ifdef RAVENOC_PKT_MASTER_AUTO_RD_EN
  localparam int unsigned VcW = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;
  logic           auto_go, arb_valid;
  logic [VcW-1:0] arb_idx, auto_vc_q;

  ravenoc_rr_arb #(.N(NumVirtChn)) u_rr_arb (
    .clk_axi   (clk_axi),
    .arst_axi  (arst_axi),
    .req       (irq_vcs),
    .advance   (auto_go),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // External requests win; the IRQ path only fires when the front end is silent.
  assign auto_go   = (rd_st == RD_IDLE) && !rx_req_valid && arb_valid;
  assign rd_launch = (rd_st == RD_IDLE) && (rx_req_valid || arb_valid);

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi)    auto_vc_q <= '0;
    else if (auto_go) auto_vc_q <= arb_idx;
  end
`else
  logic unused_irq;
  assign unused_irq = ^irq_vcs;
  assign rd_launch  = (rd_st == RD_IDLE) && rx_req_valid;
`endif

  assign w_hs      = (wr_st == WR_DATA) && txd_valid && miso.wready;
  assign r_hs      = (rd_st == RD_DATA) && miso.rvalid && rxd_ready;
  assign rd_at_len = (rd_cnt_q == rd_len_q);
  assign beat_err  = axi_resp_err(miso.rresp);

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      wr_st     <= WR_IDLE;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      wr_st <= wr_st_nxt;
      if (wr_st == WR_IDLE && tx_req_valid) begin
        wr_addr_q <= tx_addr;
        wr_len_q  <= tx_len;
        wr_cnt_q  <= '0;
      end else if (w_hs) begin
        wr_cnt_q  <= wr_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_st_nxt = wr_st;
    unique case (wr_st)
      WR_IDLE: if (tx_req_valid) wr_st_nxt = WR_ADDR;
      WR_ADDR: if (miso.awready) wr_st_nxt = WR_DATA;
      WR_DATA: if (w_hs && wr_cnt_q == wr_len_q) wr_st_nxt = WR_RESP;
      WR_RESP: if (miso.bvalid) wr_st_nxt = WR_IDLE;
      default: wr_st_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      rd_st     <= RD_IDLE;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      rd_cnt_q  <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_st <= rd_st_nxt;
      if (rd_launch) begin
        rd_addr_q <= rx_addr;
        rd_len_q  <= rx_len;
        rd_cnt_q  <= '0;
        rd_err_q  <= 1'b0;
      end else if (r_hs) begin
        rd_cnt_q  <= rd_cnt_q + 1'b1;
        rd_err_q  <= rd_err_q | beat_err;
      end
    end
  end

  // A burst hitting len without rlast is closed to the PE at once, then drained silently.
  always_comb begin
    rd_st_nxt = rd_st;
    unique case (rd_st)
      RD_IDLE:  if (rd_launch) rd_st_nxt = RD_ADDR;
      RD_ADDR:  if (miso.arready) rd_st_nxt = RD_DATA;
      RD_DATA:  if (r_hs) begin
                  if (miso.rlast)    rd_st_nxt = RD_IDLE;
                  else if (rd_at_len) rd_st_nxt = RD_DRAIN;
                end
      RD_DRAIN: if (miso.rvalid && miso.rlast) rd_st_nxt = RD_IDLE;
      default:  rd_st_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    mosi = '0;
    if (wr_st == WR_ADDR) begin
      mosi.awvalid = 1'b1;
      mosi.awid    = AXI_ID;
      mosi.awaddr  = wr_addr_q;
      mosi.awlen   = wr_len_q;
      mosi.awsize  = 3'(AxiBeatSize);
      mosi.awburst = AXI_INCR;
    end
    if (wr_st == WR_DATA) begin
      mosi.wvalid = txd_valid;
      mosi.wdata  = txd_data;
      mosi.wstrb  = '1;
      mosi.wlast  = (wr_cnt_q == wr_len_q);
    end
    mosi.bready = (wr_st == WR_RESP);
    if (rd_st == RD_ADDR) begin
      mosi.arvalid = 1'b1;
      mosi.arid    = AXI_ID;
      mosi.araddr  = rd_addr_q;
      mosi.arlen   = rd_len_q;
      mosi.arsize  = 3'(AxiBeatSize);
      mosi.arburst = AXI_INCR;
    end
    mosi.rready = ((rd_st == RD_DATA) && rxd_ready) || (rd_st == RD_DRAIN);
  end

  assign tx_req_ready = (wr_st == WR_IDLE);
  assign txd_ready    = (wr_st == WR_DATA) && miso.wready;
  assign tx_done      = (wr_st == WR_RESP) && miso.bvalid;
  assign tx_err       = tx_done && axi_resp_err(miso.bresp);

  assign rx_req_ready = (rd_st == RD_IDLE);
  assign rxd_valid    = (rd_st == RD_DATA) && miso.rvalid;
  assign rxd_data     = (rd_st == RD_DATA) ? miso.rdata : '0;
  assign rxd_last     = rxd_valid && (miso.rlast || rd_at_len);
  assign rxd_err      = rxd_last && (rd_err_q || beat_err || !miso.rlast || !rd_at_len);

endmodule
